// File: rtl/ptw_arb_pkg.sv
// Shared types for the page-table-walker AXI read-port arbiter.
package ptw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    REQ_ITLB = 1'b0,
    REQ_DTLB = 1'b1
  } req_id_t;

  localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/ptw_req_slot.sv
// One pending PTE fetch per walker: pending flag plus latched address.
module ptw_req_slot #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  set,
  input  logic                  clear,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic load;

  // A set while already pending is ignored unless the same edge retires the old entry.
  assign load = !flush && set && (!pending || clear);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pending <= 1'b0;
    end else if (flush) begin
      pending <= 1'b0;
    end else if (load) begin
      pending <= 1'b1;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      addr <= set_addr;
    end
  end

endmodule

// File: rtl/ptw_axi_arbiter.sv
// Round-robin arbiter sharing one AXI read port between the ITLB and DTLB walkers.
// Optional PTW_TIMEOUT_EN adds a WAIT watchdog that faults the owner and drains the late beat.
module ptw_axi_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
`ifdef PTW_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  ITLB_REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] ITLB_REQ_ADDR,
  output logic                  ITLB_RESP_VALID,
  output logic [DATA_WIDTH-1:0] ITLB_RESP_DATA,
  output logic                  ITLB_FAULT,
  input  logic                  DTLB_REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] DTLB_REQ_ADDR,
  output logic                  DTLB_RESP_VALID,
  output logic [DATA_WIDTH-1:0] DTLB_RESP_DATA,
  output logic                  DTLB_FAULT,
  output logic                  AXIM_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0] AXIM_ADDR,
  input  logic                  AXIM_ADDR_READY,
  input  logic                  AXIM_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] AXIM_DATA,
  input  logic                  TLB_FLUSH,
  output logic                  PTW_BUSY
);

  state_t                state, state_nx;
  req_id_t               owner, last_grant, grant;
  logic                  drop;
  logic                  start, done, expire;
  logic                  pend_i, pend_d, clr_i, clr_d;
  logic [ADDR_WIDTH-1:0] addr_i, addr_d;

`ifdef PTW_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`endif

  assign clr_i    = (done || expire) && (owner == REQ_ITLB);
  assign clr_d    = (done || expire) && (owner == REQ_DTLB);
  assign PTW_BUSY = (state != IDLE) || pend_i || pend_d;

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_itlb (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .set      (ITLB_REQ_VALID),
    .clear    (clr_i),
    .flush    (TLB_FLUSH),
    .set_addr (ITLB_REQ_ADDR),
    .pending  (pend_i),
    .addr     (addr_i)
  );

  ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot_dtlb (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .set      (DTLB_REQ_VALID),
    .clear    (clr_d),
    .flush    (TLB_FLUSH),
    .set_addr (DTLB_REQ_ADDR),
    .pending  (pend_d),
    .addr     (addr_d)
  );

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    done     = 1'b0;
    expire   = 1'b0;
    grant    = (pend_d && (!pend_i || last_grant == REQ_ITLB)) ? REQ_DTLB : REQ_ITLB;
    case (state)
      IDLE: begin
        if (!TLB_FLUSH && (pend_i || pend_d)) begin
          start    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (AXIM_ADDR_READY) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (AXIM_DATA_VALID) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
`ifdef PTW_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          expire   = 1'b1;
          state_nx = DRAIN;
        end
`endif
      end
      DRAIN: begin
`ifdef PTW_TIMEOUT_EN
        if (AXIM_DATA_VALID) begin
          state_nx = IDLE;
        end
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Registered AXI address phase and walker response stage
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      owner           <= REQ_ITLB;
      last_grant      <= REQ_ITLB;
      drop            <= 1'b0;
      AXIM_ADDR_VALID <= 1'b0;
      AXIM_ADDR       <= '0;
      ITLB_RESP_VALID <= 1'b0;
      DTLB_RESP_VALID <= 1'b0;
      ITLB_RESP_DATA  <= '0;
      DTLB_RESP_DATA  <= '0;
    end else begin
      ITLB_RESP_VALID <= 1'b0;
      DTLB_RESP_VALID <= 1'b0;
      if (start) begin
        owner           <= grant;
        AXIM_ADDR_VALID <= 1'b1;
        AXIM_ADDR       <= (grant == REQ_DTLB) ? addr_d : addr_i;
      end else if (state == ISSUE && AXIM_ADDR_READY) begin
        AXIM_ADDR_VALID <= 1'b0;
      end
      if (done) begin
        last_grant <= owner;
      end
      // A flushed walk still has to absorb its beat, but nobody hears about it.
      if (done && !drop && !TLB_FLUSH) begin
        if (owner == REQ_ITLB) begin
          ITLB_RESP_VALID <= 1'b1;
          ITLB_RESP_DATA  <= AXIM_DATA;
        end else begin
          DTLB_RESP_VALID <= 1'b1;
          DTLB_RESP_DATA  <= AXIM_DATA;
        end
      end
      if (state_nx == IDLE) begin
        drop <= 1'b0;
      end else if (TLB_FLUSH && state != IDLE) begin
        drop <= 1'b1;
      end
    end
  end

`ifdef PTW_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt        <= '0;
      ITLB_FAULT <= 1'b0;
      DTLB_FAULT <= 1'b0;
    end else begin
      cnt        <= (state == WAIT) ? cnt + 1'b1 : '0;
      ITLB_FAULT <= expire && !drop && !TLB_FLUSH && (owner == REQ_ITLB);
      DTLB_FAULT <= expire && !drop && !TLB_FLUSH && (owner == REQ_DTLB);
    end
  end
`else
  assign ITLB_FAULT = 1'b0;
  assign DTLB_FAULT = 1'b0;
`endif

endmodule

// File: tb/tb_ptw_axi_arbiter.sv
// Scoreboard bench for ptw_axi_arbiter: expected AXI addresses and walker responses are queued at stimulus time.
module tb_ptw_axi_arbiter;
  import ptw_arb_pkg::*;

  localparam int BOUND = TIMEOUT_CYCLES_DEF / 16;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        ITLB_REQ_VALID = 1'b0, DTLB_REQ_VALID = 1'b0;
  logic [63:0] ITLB_REQ_ADDR = '0, DTLB_REQ_ADDR = '0;
  logic        ITLB_RESP_VALID, DTLB_RESP_VALID, ITLB_FAULT, DTLB_FAULT;
  logic [63:0] ITLB_RESP_DATA, DTLB_RESP_DATA;
  logic        AXIM_ADDR_VALID;
  logic [63:0] AXIM_ADDR;
  logic        AXIM_ADDR_READY = 1'b0, AXIM_DATA_VALID = 1'b0;
  logic [63:0] AXIM_DATA = '0;
  logic        TLB_FLUSH = 1'b0;
  logic        PTW_BUSY;

  typedef struct packed {
    logic        who;
    logic [63:0] val;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_r[$];
  int   total = 0;
  int   bad = 0;
  logic [63:0] last_i;

  always #5 CLK = ~CLK;

  ptw_axi_arbiter #(
    .ADDR_WIDTH(64),
    .DATA_WIDTH(64)
`ifdef PTW_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .ITLB_REQ_VALID(ITLB_REQ_VALID), .ITLB_REQ_ADDR(ITLB_REQ_ADDR),
    .ITLB_RESP_VALID(ITLB_RESP_VALID), .ITLB_RESP_DATA(ITLB_RESP_DATA), .ITLB_FAULT(ITLB_FAULT),
    .DTLB_REQ_VALID(DTLB_REQ_VALID), .DTLB_REQ_ADDR(DTLB_REQ_ADDR),
    .DTLB_RESP_VALID(DTLB_RESP_VALID), .DTLB_RESP_DATA(DTLB_RESP_DATA), .DTLB_FAULT(DTLB_FAULT),
    .AXIM_ADDR_VALID(AXIM_ADDR_VALID), .AXIM_ADDR(AXIM_ADDR), .AXIM_ADDR_READY(AXIM_ADDR_READY),
    .AXIM_DATA_VALID(AXIM_DATA_VALID), .AXIM_DATA(AXIM_DATA),
    .TLB_FLUSH(TLB_FLUSH), .PTW_BUSY(PTW_BUSY)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic match_resp(input logic who, input logic vld, input logic [63:0] data);
    exp_t e;
    if (exp_r.size() == 0) begin
      check(who ? "dtlb_resp_unexpected" : "itlb_resp_unexpected", 64'(vld), 64'd0);
    end else begin
      e = exp_r.pop_front();
      check("resp_owner", 64'(who), 64'(e.who));
      check("resp_data", data, e.val);
    end
  endtask

  always @(negedge CLK) begin
    if (RSTN === 1'b1) begin
      if (ITLB_RESP_VALID === 1'b1) match_resp(1'b0, ITLB_RESP_VALID, ITLB_RESP_DATA);
      if (DTLB_RESP_VALID === 1'b1) match_resp(1'b1, DTLB_RESP_VALID, DTLB_RESP_DATA);
`ifndef PTW_TIMEOUT_EN
      if (ITLB_FAULT !== 1'b0 || DTLB_FAULT !== 1'b0)
        check("fault_tied", 64'({ITLB_FAULT, DTLB_FAULT}), 64'd0);
`endif
    end
  end

  task automatic do_reset();
    RSTN = 1'b0;
    repeat (2) tick();
    RSTN = 1'b1;
    tick();
  endtask

  task automatic req(input logic who, input logic [63:0] a);
    if (who) begin
      DTLB_REQ_VALID = 1'b1;
      DTLB_REQ_ADDR  = a;
    end else begin
      ITLB_REQ_VALID = 1'b1;
      ITLB_REQ_ADDR  = a;
    end
    exp_a.push_back(exp_t'{who, a});
    tick();
    ITLB_REQ_VALID = 1'b0;
    DTLB_REQ_VALID = 1'b0;
  endtask

  task automatic req_pair(input logic first, input logic [63:0] ai, input logic [63:0] ad);
    ITLB_REQ_VALID = 1'b1;
    ITLB_REQ_ADDR  = ai;
    DTLB_REQ_VALID = 1'b1;
    DTLB_REQ_ADDR  = ad;
    if (first) begin
      exp_a.push_back(exp_t'{1'b1, ad});
      exp_a.push_back(exp_t'{1'b0, ai});
    end else begin
      exp_a.push_back(exp_t'{1'b0, ai});
      exp_a.push_back(exp_t'{1'b1, ad});
    end
    tick();
    ITLB_REQ_VALID = 1'b0;
    DTLB_REQ_VALID = 1'b0;
  endtask

  task automatic wait_addr_valid();
    int n = 0;
    while (AXIM_ADDR_VALID !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    check("addr_valid_wait", 64'(AXIM_ADDR_VALID), 64'd1);
  endtask

  // Acts as the AXI slave for one walk; optionally injects a DTLB request and a flush during WAIT.
  task automatic serve(input int rdy_wait, input int dat_wait, input logic [63:0] data,
                       input bit pulse_d, input logic [63:0] d_addr, input bit flush);
    exp_t e;
    wait_addr_valid();
    if (AXIM_ADDR_VALID !== 1'b1) return;
    if (exp_a.size() == 0) begin
      check("addr_unexpected", 64'(AXIM_ADDR_VALID), 64'd0);
      return;
    end
    e = exp_a.pop_front();
    for (int k = 0; k < rdy_wait; k++) begin
      check("addr_hold", AXIM_ADDR, e.val);
      check("valid_hold", 64'(AXIM_ADDR_VALID), 64'd1);
      tick();
    end
    check("addr", AXIM_ADDR, e.val);
    AXIM_ADDR_READY = 1'b1;
    tick();
    AXIM_ADDR_READY = 1'b0;
    check("valid_drop", 64'(AXIM_ADDR_VALID), 64'd0);
    for (int k = 0; k < dat_wait; k++) begin
      if (pulse_d && k == 0) begin
        DTLB_REQ_VALID = 1'b1;
        DTLB_REQ_ADDR  = d_addr;
        exp_a.push_back(exp_t'{1'b1, d_addr});
      end
      if (flush && k == 1) begin
        TLB_FLUSH = 1'b1;
        exp_a.delete();
      end
      tick();
      DTLB_REQ_VALID = 1'b0;
      TLB_FLUSH      = 1'b0;
    end
    AXIM_DATA_VALID = 1'b1;
    AXIM_DATA       = data;
    if (!flush) exp_r.push_back(exp_t'{e.who, data});
    tick();
    AXIM_DATA_VALID = 1'b0;
    AXIM_DATA       = {$urandom, $urandom};
    check(e.who ? "dtlb_resp_pulse" : "itlb_resp_pulse",
          64'(e.who ? DTLB_RESP_VALID : ITLB_RESP_VALID), 64'(!flush));
    check(e.who ? "itlb_resp_quiet" : "dtlb_resp_quiet",
          64'(e.who ? ITLB_RESP_VALID : DTLB_RESP_VALID), 64'd0);
    if (!e.who && !flush) last_i = data;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_valid"}, 64'(AXIM_ADDR_VALID), 64'd0);
    check({tag, "_addr"}, AXIM_ADDR, 64'd0);
    check({tag, "_itlb_resp"}, 64'({ITLB_RESP_VALID, ITLB_FAULT}), 64'd0);
    check({tag, "_dtlb_resp"}, 64'({DTLB_RESP_VALID, DTLB_FAULT}), 64'd0);
    check({tag, "_itlb_data"}, ITLB_RESP_DATA, 64'd0);
    check({tag, "_dtlb_data"}, DTLB_RESP_DATA, 64'd0);
    check({tag, "_busy"}, 64'(PTW_BUSY), 64'd0);
  endtask

  initial begin
    logic [63:0] d0, d1;
    tick();
    check_all_zero("reset");
    RSTN = 1'b1;
    tick();

    // Lone ITLB walk: READY on the 2nd ISSUE cycle, data 3 cycles after accept.
    req(1'b0, 64'h8000_1008);
    check("issue_latency", 64'(AXIM_ADDR_VALID), 64'd0);
    check("busy_pending", 64'(PTW_BUSY), 64'd1);
    serve(1, 3, 64'h2000_00CF, 1'b0, 64'd0, 1'b0);
    repeat (3) tick();
    check("resp_data_hold", ITLB_RESP_DATA, 64'h2000_00CF);
    check("idle_not_busy", 64'(PTW_BUSY), 64'd0);

    // Simultaneous pairs: DTLB wins after reset, ITLB wins once DTLB was last served.
    do_reset();
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    req_pair(1'b1, 64'h8000_2000, 64'h9000_2000);
    serve(0, 1, d0, 1'b0, 64'd0, 1'b0);
    serve(0, 1, d1, 1'b0, 64'd0, 1'b0);
    req(1'b1, 64'h9000_3000);
    serve(0, 0, {$urandom, $urandom}, 1'b0, 64'd0, 1'b0);
    req_pair(1'b0, 64'h8000_4000, 64'h9000_4000);
    serve(2, 2, {$urandom, $urandom}, 1'b0, 64'd0, 1'b0);
    serve(0, 4, {$urandom, $urandom}, 1'b0, 64'd0, 1'b0);

    // DTLB captured while an ITLB walk waits; issued one cycle after ITLB_RESP_VALID.
    req(1'b0, 64'h8000_5000);
    serve(0, 3, 64'h1111_2222_3333_4444, 1'b1, 64'h9000_5008, 1'b0);
    check("b2b_not_yet", 64'(AXIM_ADDR_VALID), 64'd0);
    tick();
    check("b2b_valid", 64'(AXIM_ADDR_VALID), 64'd1);
    check("b2b_addr", AXIM_ADDR, 64'h9000_5008);
    serve(0, 1, 64'h5555_6666_7777_8888, 1'b0, 64'd0, 1'b0);

    // Flush during WAIT with DTLB pending: walk dropped, slot cleared.
    req(1'b0, 64'h8000_6000);
    serve(0, 3, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'h9000_6000, 1'b1);
    check("flush_busy", 64'(PTW_BUSY), 64'd0);
    check("flush_data_kept", ITLB_RESP_DATA, last_i);
    repeat (3) tick();
    check("flush_no_issue", 64'(AXIM_ADDR_VALID), 64'd0);

    // Reset in ISSUE, then a stray beat.
    req(1'b0, 64'h8000_7000);
    wait_addr_valid();
    tick();
    RSTN = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_a.delete();
    tick();
    RSTN = 1'b1;
    AXIM_DATA_VALID = 1'b1;
    AXIM_DATA       = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    AXIM_DATA_VALID = 1'b0;
    tick();
    check_all_zero("stray_beat");

`ifdef PTW_TIMEOUT_EN
    begin
      int n = 0;
      req(1'b1, 64'h9000_8000);
      wait_addr_valid();
      void'(exp_a.pop_front());
      AXIM_ADDR_READY = 1'b1;
      tick();
      AXIM_ADDR_READY = 1'b0;
      while (DTLB_FAULT !== 1'b1 && n < BOUND) begin
        tick();
        n++;
      end
      check("timeout_cycles", 64'(n), 64'd16);
      check("timeout_itlb_quiet", 64'(ITLB_FAULT), 64'd0);
      tick();
      check("fault_one_cycle", 64'(DTLB_FAULT), 64'd0);
      check("drain_busy", 64'(PTW_BUSY), 64'd1);
      AXIM_DATA_VALID = 1'b1;
      tick();
      AXIM_DATA_VALID = 1'b0;
      check("late_beat_dropped", 64'(DTLB_RESP_VALID), 64'd0);
      req(1'b0, 64'h8000_9000);
      serve(0, 2, 64'hC0DE_0000_0000_0009, 1'b0, 64'd0, 1'b0);
    end
`endif

    repeat (3) tick();
    check("resp_queue_empty", 64'(exp_r.size()), 64'd0);
    check("addr_queue_empty", 64'(exp_a.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
